// File: rtl/qm_pkg.sv
// Shared definitions for the qm ID stage: opcode constants, ID/EX bundle,
// decode FSM states and small decode helpers.
package qm_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_STORE_LO = 6'h28;
    localparam logic [5:0] OP_STORE_HI = 6'h2B;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
    } idex_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } qm_state_e;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic [31:0] imm_ext(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
            imm_ext = {16'h0000, instr[15:0]};
        else
            imm_ext = {{16{instr[15]}}, instr[15:0]};
    endfunction

    function automatic logic rs_is_used(input logic [5:0] op);
        rs_is_used = !(op == OP_J || op == OP_JAL);
    endfunction

    function automatic logic rt_is_used(input logic [5:0] op);
        rt_is_used = (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) ||
                     (op >= OP_STORE_LO && op <= OP_STORE_HI);
    endfunction

endpackage

// File: rtl/qm_decode_if.sv
// Signal bundle between the qm ID stage and its neighbours (IF/ID latch,
// regfile, EX/MEM/WB writers, ID/EX consumers).
interface qm_decode_if;
    import qm_pkg::*;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_stall;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        ex_stall;
    logic        ex_flush;
    logic        ex_we;
    logic [4:0]  ex_wa;
    logic        ex_is_load;
    logic [31:0] ex_result;
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [31:0] mem_result;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [31:0] id_imm;
    logic [31:0] id_op1;
    logic [31:0] id_op2;

    // The surrounding pipeline drives the stage through master.
    modport master (
        output if_valid, if_instr, if_pc, rf_rd1, rf_rd2, ex_stall, ex_flush,
               ex_we, ex_wa, ex_is_load, ex_result, mem_we, mem_wa, mem_result,
               wb_we, wb_wa, wb_wd,
        input  id_stall, rf_ra1, rf_ra2, id_valid, id_pc, id_opcode, id_funct,
               id_rs, id_rt, id_rd, id_shamt, id_imm, id_op1, id_op2
    );

    modport slave (
        input  if_valid, if_instr, if_pc, rf_rd1, rf_rd2, ex_stall, ex_flush,
               ex_we, ex_wa, ex_is_load, ex_result, mem_we, mem_wa, mem_result,
               wb_we, wb_wa, wb_wd,
        output id_stall, rf_ra1, rf_ra2, id_valid, id_pc, id_opcode, id_funct,
               id_rs, id_rt, id_rd, id_shamt, id_imm, id_op1, id_op2
    );

endinterface

// File: rtl/qm_fwd_mux.sv
// Per-source operand select (EX > MEM > WB > regfile) plus writer match flags.
// QM_FORWARDING_EN selects the bypass network; otherwise only regfile data.
module qm_fwd_mux
    import qm_pkg::*;
(
    input  logic [4:0]  addr,
    input  logic [31:0] rf_data,
    input  logic        ex_we,
    input  logic [4:0]  ex_wa,
    input  logic        ex_is_load,
    input  logic [31:0] ex_result,
    input  logic        mem_we,
    input  logic [4:0]  mem_wa,
    input  logic [31:0] mem_result,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    output logic [31:0] data,
    output logic        ex_hit,
    output logic        ex_load_hit,
    output logic        mem_hit,
    output logic        wb_hit
);

    logic nz;

    // $0 never matches a writer, so it can neither forward nor stall.
    assign nz          = (addr != 5'd0);
    assign ex_hit      = nz && ex_we  && (ex_wa  == addr);
    assign ex_load_hit = ex_hit && ex_is_load;
    assign mem_hit     = nz && mem_we && (mem_wa == addr);
    assign wb_hit      = nz && wb_we  && (wb_wa  == addr);

`ifdef QM_FORWARDING_EN
    always_comb begin
        data = rf_data;
        if (!nz)
            data = 32'h0;
        else if (ex_hit && !ex_is_load)
            data = ex_result;
        else if (mem_hit)
            data = mem_result;
        else if (wb_hit)
            data = wb_wd;
    end
`else
    logic unused_fwd;

    assign data       = nz ? rf_data : 32'h0;
    assign unused_fwd = ^{ex_result, mem_result, wb_wd};
`endif

endmodule

// File: rtl/qm_decode.sv
// qm ID stage: field decode, operand resolution, hazard stall and ID/EX register.
// Optional bypass network enabled by defining QM_FORWARDING_EN.
module qm_decode
    import qm_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    qm_decode_if.slave    bus
);

    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_used;
    logic        rt_used;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rs_ex_hit, rs_ld_hit, rs_mem_hit, rs_wb_hit;
    logic        rt_ex_hit, rt_ld_hit, rt_mem_hit, rt_wb_hit;
    logic        hazard;
    logic        stall;
    idex_t       idex_d, idex_q;
    qm_state_e   state_d, state_q;

    assign instr   = bus.if_instr;
    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rs_used = rs_is_used(opcode);
    assign rt_used = rt_is_used(opcode);

    assign bus.rf_ra1 = rs;
    assign bus.rf_ra2 = rt;

    qm_fwd_mux u_fwd_rs (
        .addr        (rs),
        .rf_data     (bus.rf_rd1),
        .ex_we       (bus.ex_we),
        .ex_wa       (bus.ex_wa),
        .ex_is_load  (bus.ex_is_load),
        .ex_result   (bus.ex_result),
        .mem_we      (bus.mem_we),
        .mem_wa      (bus.mem_wa),
        .mem_result  (bus.mem_result),
        .wb_we       (bus.wb_we),
        .wb_wa       (bus.wb_wa),
        .wb_wd       (bus.wb_wd),
        .data        (rs_data),
        .ex_hit      (rs_ex_hit),
        .ex_load_hit (rs_ld_hit),
        .mem_hit     (rs_mem_hit),
        .wb_hit      (rs_wb_hit)
    );

    qm_fwd_mux u_fwd_rt (
        .addr        (rt),
        .rf_data     (bus.rf_rd2),
        .ex_we       (bus.ex_we),
        .ex_wa       (bus.ex_wa),
        .ex_is_load  (bus.ex_is_load),
        .ex_result   (bus.ex_result),
        .mem_we      (bus.mem_we),
        .mem_wa      (bus.mem_wa),
        .mem_result  (bus.mem_result),
        .wb_we       (bus.wb_we),
        .wb_wa       (bus.wb_wa),
        .wb_wd       (bus.wb_wd),
        .data        (rt_data),
        .ex_hit      (rt_ex_hit),
        .ex_load_hit (rt_ld_hit),
        .mem_hit     (rt_mem_hit),
        .wb_hit      (rt_wb_hit)
    );

`ifdef QM_FORWARDING_EN
    logic unused_hits;

    // Only a load in EX is too late to bypass.
    assign hazard      = bus.if_valid && ((rs_used && rs_ld_hit) || (rt_used && rt_ld_hit));
    assign unused_hits = ^{rs_ex_hit, rs_mem_hit, rs_wb_hit, rt_ex_hit, rt_mem_hit, rt_wb_hit};
`else
    logic unused_ld;

    // No bypass: wait until every in-flight writer of a used source has retired.
    assign hazard    = bus.if_valid &&
                       ((rs_used && (rs_ex_hit || rs_mem_hit || rs_wb_hit)) ||
                        (rt_used && (rt_ex_hit || rt_mem_hit || rt_wb_hit)));
    assign unused_ld = rs_ld_hit ^ rt_ld_hit;
`endif

    always_comb begin
        idex_d  = idex_q;
        state_d = state_q;
        stall   = 1'b0;
        if (bus.ex_flush) begin
            idex_d.valid = 1'b0;
            state_d      = ST_RUN;
        end else if (bus.ex_stall) begin
            stall = 1'b1;
        end else if (hazard) begin
            idex_d.valid = 1'b0;
            stall        = 1'b1;
`ifdef QM_FORWARDING_EN
            state_d      = ST_BUBBLE;
`else
            state_d      = ST_RUN;
`endif
        end else begin
            // BUBBLE always returns to RUN: the load is now in MEM and bypassed.
            idex_d.valid  = bus.if_valid;
            idex_d.pc     = bus.if_pc;
            idex_d.opcode = opcode;
            idex_d.funct  = instr[5:0];
            idex_d.rs     = rs;
            idex_d.rt     = rt;
            idex_d.rd     = instr[15:11];
            idex_d.shamt  = instr[10:6];
            idex_d.imm    = imm_ext(instr);
            idex_d.op1    = rs_data;
            idex_d.op2    = rt_data;
            state_d       = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idex_q  <= '0;
            state_q <= ST_RUN;
        end else begin
            idex_q  <= idex_d;
            state_q <= state_d;
        end
    end

    assign bus.id_stall  = reset_n && stall;
    assign bus.id_valid  = idex_q.valid;
    assign bus.id_pc     = idex_q.pc;
    assign bus.id_opcode = idex_q.opcode;
    assign bus.id_funct  = idex_q.funct;
    assign bus.id_rs     = idex_q.rs;
    assign bus.id_rt     = idex_q.rt;
    assign bus.id_rd     = idex_q.rd;
    assign bus.id_shamt  = idex_q.shamt;
    assign bus.id_imm    = idex_q.imm;
    assign bus.id_op1    = idex_q.op1;
    assign bus.id_op2    = idex_q.op2;

endmodule

// File: tb/tb_qm_decode.sv
// Directed bench for qm_decode: stimulus pushes expected ID/EX bundles into a
// queue, an independent monitor pops and compares on each newly captured output.
module tb_qm_decode;
    import qm_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic held = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    qm_decode_if bus();

    qm_decode dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] rt);
        exp_t e;
        e.pc = pc; e.imm = imm; e.op1 = op1; e.op2 = op2; e.rt = rt;
        q.push_back(e);
    endtask

    task automatic clr_writers();
        bus.ex_we = 0; bus.ex_wa = 0; bus.ex_is_load = 0; bus.ex_result = 0;
        bus.mem_we = 0; bus.mem_wa = 0; bus.mem_result = 0;
        bus.wb_we = 0; bus.wb_wa = 0; bus.wb_wd = 0;
    endtask

    // A posedge with ex_stall (and no flush/reset) leaves the old bundle in place.
    always @(posedge clk) held = reset_n && bus.ex_stall && !bus.ex_flush;

    always @(negedge clk) begin
        if (reset_n && bus.id_valid && !held) begin
            if (q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_output: id_pc %h with nothing expected", bus.id_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("id_pc",  bus.id_pc, e.pc);
                chk("id_imm", bus.id_imm, e.imm);
                chk("id_op1", bus.id_op1, e.op1);
                chk("id_op2", bus.id_op2, e.op2);
                chk("id_rt",  {27'd0, bus.id_rt}, e.rt);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_writers();
        bus.ex_stall = 0; bus.ex_flush = 0;
        bus.rf_rd1 = 32'h1111; bus.rf_rd2 = 32'h2222;
        issue(32'h2402FFFF, 32'h100);

        // reset held two cycles with a valid instruction present
        repeat (2) tick();
        chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_id_pc",    bus.id_pc, 32'd0);
        chk("rst_id_imm",   bus.id_imm, 32'd0);
        chk("rst_id_op1",   bus.id_op1, 32'd0);
        chk("rst_id_op2",   bus.id_op2, 32'd0);
        chk("rst_id_rt",    {27'd0, bus.id_rt}, 32'd0);
        chk("rst_id_stall", {31'd0, bus.id_stall}, 32'd0);
        reset_n = 1'b1;

        // ADDIU $2,$0,-1: sign-extended immediate
        #1;
        chk("addiu_stall", {31'd0, bus.id_stall}, 32'd0);
        chk("addiu_ra2",   {27'd0, bus.rf_ra2}, 32'd2);
        expect_out(32'h100, 32'hFFFFFFFF, 32'h0, 32'h2222, 32'd2);
        tick();

        // ORI $2,$0,0xFFFF: zero-extended immediate
        issue(32'h3402FFFF, 32'h104);
        expect_out(32'h104, 32'h0000FFFF, 32'h0, 32'h2222, 32'd2);
        tick();

        // ADDU $3,$1,$2
        issue(32'h00221821, 32'h108);
`ifdef QM_FORWARDING_EN
        bus.ex_we = 1;  bus.ex_wa = 1;  bus.ex_result = 32'h11;
        bus.mem_we = 1; bus.mem_wa = 1; bus.mem_result = 32'h22;
        bus.wb_we = 1;  bus.wb_wa = 2;  bus.wb_wd = 32'h33;
        bus.rf_rd2 = 32'h44;
        #1;
        chk("fwd_stall", {31'd0, bus.id_stall}, 32'd0);
        expect_out(32'h108, 32'h00001821, 32'h11, 32'h33, 32'd2);
`else
        #1;
        chk("addu_stall", {31'd0, bus.id_stall}, 32'd0);
        expect_out(32'h108, 32'h00001821, 32'h1111, 32'h2222, 32'd2);
`endif
        chk("addu_ra1", {27'd0, bus.rf_ra1}, 32'd1);
        tick();
        clr_writers();
        bus.rf_rd2 = 32'h2222;

        // ADDU $3,$0,$0 with every writer (including a load) aimed at $0
        issue(32'h00001821, 32'h10C);
        bus.ex_we = 1;  bus.ex_wa = 0; bus.ex_is_load = 1; bus.ex_result = 32'h99;
        bus.mem_we = 1; bus.mem_wa = 0; bus.mem_result = 32'h98;
        bus.wb_we = 1;  bus.wb_wa = 0;  bus.wb_wd = 32'h97;
        bus.rf_rd1 = 32'hDEAD; bus.rf_rd2 = 32'hBEEF;
        #1;
        chk("r0_stall", {31'd0, bus.id_stall}, 32'd0);
        expect_out(32'h10C, 32'h00001821, 32'h0, 32'h0, 32'd0);
        tick();
        clr_writers();
        bus.rf_rd1 = 32'h1111; bus.rf_rd2 = 32'h2222;

        // SW $5,0($1) behind a load to $5
        issue(32'hAC250000, 32'h110);
        bus.ex_we = 1; bus.ex_wa = 5; bus.ex_is_load = 1; bus.ex_result = 32'h66;
        #1;
        chk("lu_stall", {31'd0, bus.id_stall}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, bus.id_valid}, 32'd0);
        clr_writers();
        bus.mem_we = 1; bus.mem_wa = 5; bus.mem_result = 32'h55;
`ifdef QM_FORWARDING_EN
        #1;
        chk("lu_release", {31'd0, bus.id_stall}, 32'd0);
        expect_out(32'h110, 32'h0, 32'h1111, 32'h55, 32'd5);
        tick();
`else
        #1;
        chk("nf_mem_stall", {31'd0, bus.id_stall}, 32'd1);
        tick();
        chk("nf_mem_bubble", {31'd0, bus.id_valid}, 32'd0);
        clr_writers();
        bus.wb_we = 1; bus.wb_wa = 5; bus.wb_wd = 32'h55;
        #1;
        chk("nf_wb_stall", {31'd0, bus.id_stall}, 32'd1);
        tick();
        chk("nf_wb_bubble", {31'd0, bus.id_valid}, 32'd0);
        clr_writers();
        bus.rf_rd2 = 32'h55;
        #1;
        chk("nf_release", {31'd0, bus.id_stall}, 32'd0);
        expect_out(32'h110, 32'h0, 32'h1111, 32'h55, 32'd5);
        tick();
`endif
        clr_writers();
        bus.rf_rd2 = 32'h2222;

        // J with rs field = 5: rs unused, no hazard against a load to $5
        issue(32'h08A00000, 32'h114);
        bus.ex_we = 1; bus.ex_wa = 5; bus.ex_is_load = 1; bus.ex_result = 32'h77;
        #1;
        chk("j_stall", {31'd0, bus.id_stall}, 32'd0);
        expect_out(32'h114, 32'h0, 32'h1111, 32'h0, 32'd0);
        tick();

        // ADDIU $5,$0,1: rt is a destination, load to $5 must not stall
        issue(32'h24050001, 32'h118);
        #1;
        chk("addiu_rt_stall", {31'd0, bus.id_stall}, 32'd0);
        expect_out(32'h118, 32'h1, 32'h0, 32'h2222, 32'd5);
        tick();
        clr_writers();

        // ex_stall holds ID/EX
        issue(32'h3402FFFF, 32'h11C);
        bus.ex_stall = 1;
        #1;
        chk("exst_stall", {31'd0, bus.id_stall}, 32'd1);
        tick();
        chk("exst_hold_pc", bus.id_pc, 32'h118);
        bus.ex_stall = 0;
        expect_out(32'h11C, 32'h0000FFFF, 32'h0, 32'h2222, 32'd2);
        tick();

        // flush beats stall
        issue(32'h2402FFFF, 32'h120);
        bus.ex_flush = 1; bus.ex_stall = 1;
        #1;
        chk("flush_stall", {31'd0, bus.id_stall}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, bus.id_valid}, 32'd0);
        bus.ex_flush = 0; bus.ex_stall = 0;

        // reset while stalled, then resume
        bus.ex_stall = 1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.ex_stall = 0;
        #1;
        chk("rst_mid_stall", {31'd0, bus.id_stall}, 32'd0);
        chk("rst_mid_pc", bus.id_pc, 32'd0);
        issue(32'h2402FFFF, 32'h124);
        expect_out(32'h124, 32'hFFFFFFFF, 32'h0, 32'h2222, 32'd2);
        tick();

        bus.if_valid = 1'b0;
        repeat (3) tick();
        chk("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
